// File: rtl/display_sequencer_if.sv
// Matrix handshake and display-controller signals for display_sequencer.
// master: compute/display side; slave: the sequencer.
interface display_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_c11;
  logic [7:0] in_c12;
  logic [7:0] in_c21;
  logic [7:0] in_c22;
  logic       disp_reg_en;
  logic [7:0] disp_c11;
  logic [7:0] disp_c12;
  logic [7:0] disp_c21;
  logic [7:0] disp_c22;
  logic       disp_is_done;

  modport master (
    output in_valid, in_c11, in_c12, in_c21, in_c22, disp_is_done,
    input  in_ready, disp_reg_en, disp_c11, disp_c12, disp_c21, disp_c22
  );

  modport slave (
    input  in_valid, in_c11, in_c12, in_c21, in_c22, disp_is_done,
    output in_ready, disp_reg_en, disp_c11, disp_c12, disp_c21, disp_c22
  );
endinterface

// File: rtl/display_sequencer.sv
// Buffers 2x2 result matrices and sequences them into the display controller
// with a done watchdog and dwell timer. Optional frame counter: DISP_SEQ_FRAME_CNT_EN.
module display_sequencer #(
  parameter int unsigned DWELL_CYCLES   = 100000000,
  parameter int unsigned TIMEOUT_CYCLES = 200000000,
  parameter int unsigned TMR_W          = 28
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               abort,
  display_sequencer_if.slave bus,
  output logic               busy,
  output logic               frame_done,
  output logic               timeout_err
`ifdef DISP_SEQ_FRAME_CNT_EN
  ,
  output logic [15:0]        frame_cnt
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DWELL = 2'd3;

  localparam logic [TMR_W-1:0] DWELL_LAST   = TMR_W'(DWELL_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic             pend_vld_q, pend_vld_d;
  logic [31:0]      pend_q, pend_d;
  logic [31:0]      disp_q, disp_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             frame_done_q, frame_done_d;
  logic             timeout_err_q, timeout_err_d;
  logic             accept;
`ifdef DISP_SEQ_FRAME_CNT_EN
  logic [15:0]      frame_cnt_q, frame_cnt_d;
`endif

  // abort blocks the accept, so an offered matrix is never captured that cycle
  assign accept = bus.in_valid && !pend_vld_q && !abort;

  always_comb begin
    state_d       = state_q;
    pend_vld_d    = pend_vld_q;
    pend_d        = pend_q;
    disp_d        = disp_q;
    timer_d       = timer_q;
    frame_done_d  = 1'b0;
    timeout_err_d = timeout_err_q;

    if (accept) begin
      pend_d     = {bus.in_c11, bus.in_c12, bus.in_c21, bus.in_c22};
      pend_vld_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (pend_vld_q) begin
          disp_d     = pend_q;
          pend_vld_d = 1'b0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // done wins over a watchdog expiry in the same cycle
        if (bus.disp_is_done) begin
          timer_d = '0;
          state_d = S_DWELL;
        end else if (timer_q == TIMEOUT_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DWELL: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == DWELL_LAST) begin
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d       = S_IDLE;
      pend_vld_d    = 1'b0;
      timer_d       = '0;
      disp_d        = disp_q;
      frame_done_d  = 1'b0;
      timeout_err_d = timeout_err_q;
    end
  end

`ifdef DISP_SEQ_FRAME_CNT_EN
  always_comb begin
    frame_cnt_d = frame_cnt_q + {15'd0, frame_done_d};
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      pend_vld_q    <= 1'b0;
      pend_q        <= '0;
      disp_q        <= '0;
      timer_q       <= '0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef DISP_SEQ_FRAME_CNT_EN
      frame_cnt_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      pend_vld_q    <= pend_vld_d;
      pend_q        <= pend_d;
      disp_q        <= disp_d;
      timer_q       <= timer_d;
      frame_done_q  <= frame_done_d;
      timeout_err_q <= timeout_err_d;
`ifdef DISP_SEQ_FRAME_CNT_EN
      frame_cnt_q   <= frame_cnt_d;
`endif
    end
  end

  assign bus.in_ready    = !pend_vld_q;
  assign bus.disp_reg_en = (state_q == S_LOAD) && !abort;
  assign bus.disp_c11    = disp_q[31:24];
  assign bus.disp_c12    = disp_q[23:16];
  assign bus.disp_c21    = disp_q[15:8];
  assign bus.disp_c22    = disp_q[7:0];
  assign busy            = (state_q != S_IDLE);
  assign frame_done      = frame_done_q;
  assign timeout_err     = timeout_err_q;
`ifdef DISP_SEQ_FRAME_CNT_EN
  assign frame_cnt       = frame_cnt_q;
`endif

endmodule

// File: tb/tb_display_sequencer.sv
// Directed table-driven bench for display_sequencer (DWELL=4, TIMEOUT=16)
// plus hand-written sequences for tie, timeout, abort and async reset.
module tb_display_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic abort = 1'b0;
  logic busy, frame_done, timeout_err;
`ifdef DISP_SEQ_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int total = 0;
  int bad   = 0;

  display_sequencer_if bus ();

  display_sequencer #(
    .DWELL_CYCLES  (4),
    .TIMEOUT_CYCLES(16),
    .TMR_W         (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .abort      (abort),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done),
    .timeout_err(timeout_err)
`ifdef DISP_SEQ_FRAME_CNT_EN
    ,
    .frame_cnt  (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        vld;
    logic [31:0] dat;
    logic        done;
    logic        rdy;
    logic        en;
    logic        bsy;
    logic        fd;
    logic [31:0] disp;
  } vec_t;

  localparam int NV = 35;
  vec_t vecs [NV];

  localparam logic [31:0] M0 = 32'h01020304;
  localparam logic [31:0] MA = 32'h11121314;
  localparam logic [31:0] MB = 32'h21222324;
  localparam logic [31:0] MC = 32'h31323334;

  function automatic vec_t mk(logic v, logic [31:0] d, logic dn, logic r,
                              logic e, logic b, logic f, logic [31:0] dd);
    vec_t x;
    x.vld = v; x.dat = d; x.done = dn; x.rdy = r;
    x.en = e; x.bsy = b; x.fd = f; x.disp = dd;
    return x;
  endfunction

  function automatic logic [31:0] rd_disp();
    return {bus.disp_c11, bus.disp_c12, bus.disp_c21, bus.disp_c22};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic offer(input logic v, input logic [31:0] d);
    bus.in_valid = v;
    {bus.in_c11, bus.in_c12, bus.in_c21, bus.in_c22} = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vecs[0]  = mk(1, M0, 0, 1, 0, 0, 0, 32'h0);
    vecs[1]  = mk(0, 0,  0, 0, 0, 0, 0, 32'h0);
    vecs[2]  = mk(0, 0,  0, 1, 1, 1, 0, M0);
    vecs[3]  = mk(0, 0,  0, 1, 0, 1, 0, M0);
    vecs[4]  = mk(0, 0,  0, 1, 0, 1, 0, M0);
    vecs[5]  = mk(0, 0,  1, 1, 0, 1, 0, M0);
    for (int i = 6; i <= 9; i++) vecs[i] = mk(0, 0, 0, 1, 0, 1, 0, M0);
    vecs[10] = mk(0, 0,  0, 1, 0, 0, 1, M0);
    vecs[11] = mk(1, MA, 0, 1, 0, 0, 0, M0);
    vecs[12] = mk(1, MB, 0, 0, 0, 0, 0, M0);
    vecs[13] = mk(1, MB, 0, 1, 1, 1, 0, MA);
    vecs[14] = mk(1, MC, 0, 0, 0, 1, 0, MA);
    vecs[15] = mk(1, MC, 1, 0, 0, 1, 0, MA);
    for (int i = 16; i <= 19; i++) vecs[i] = mk(1, MC, 0, 0, 0, 1, 0, MA);
    vecs[20] = mk(1, MC, 0, 0, 0, 0, 1, MA);
    vecs[21] = mk(1, MC, 0, 1, 1, 1, 0, MB);
    vecs[22] = mk(0, 0,  1, 0, 0, 1, 0, MB);
    for (int i = 23; i <= 26; i++) vecs[i] = mk(0, 0, 0, 0, 0, 1, 0, MB);
    vecs[27] = mk(0, 0,  0, 0, 0, 0, 1, MB);
    vecs[28] = mk(0, 0,  0, 1, 1, 1, 0, MC);
    vecs[29] = mk(0, 0,  1, 1, 0, 1, 0, MC);
    for (int i = 30; i <= 33; i++) vecs[i] = mk(0, 0, 0, 1, 0, 1, 0, MC);
    vecs[34] = mk(0, 0,  0, 1, 0, 0, 1, MC);

    offer(0, 32'h0);
    bus.disp_is_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {26'd0, bus.in_ready, bus.disp_reg_en, busy, frame_done, timeout_err, rd_disp()},
        {26'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      offer(vecs[i].vld, vecs[i].dat);
      bus.disp_is_done = vecs[i].done;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          {26'd0, bus.in_ready, bus.disp_reg_en, busy, frame_done, timeout_err, rd_disp()},
          {26'd0, vecs[i].rdy, vecs[i].en, vecs[i].bsy, vecs[i].fd, 1'b0, vecs[i].disp});
      @(posedge clk);
      #1;
    end
    offer(0, 32'h0);
    bus.disp_is_done = 1'b0;

    // done arriving exactly on the last watchdog cycle
    offer(1, 32'h51525354); tick();
    offer(0, 32'h0); tick();
    chk("tie_load", {63'd0, bus.disp_reg_en}, 64'd1);
    tick();
    repeat (15) tick();
    chk("tie_pre", {62'd0, busy, timeout_err}, {62'd0, 1'b1, 1'b0});
    bus.disp_is_done = 1'b1; tick();
    bus.disp_is_done = 1'b0;
    chk("tie_dwell", {62'd0, busy, timeout_err}, {62'd0, 1'b1, 1'b0});
    repeat (3) tick();
    chk("tie_fd_early", {63'd0, frame_done}, 64'd0);
    tick();
    chk("tie_fd", {62'd0, frame_done, busy}, {62'd0, 1'b1, 1'b0});

    // watchdog expiry
    offer(1, 32'h41424344); tick();
    offer(0, 32'h0); tick(); tick();
    repeat (15) tick();
    chk("to_pre", {62'd0, busy, timeout_err}, {62'd0, 1'b1, 1'b0});
    tick();
    chk("to_err", {61'd0, busy, timeout_err, frame_done}, {61'd0, 1'b0, 1'b1, 1'b0});
    offer(1, 32'h45464748); tick();
    offer(0, 32'h0); tick();
    chk("to_reload", {30'd0, bus.disp_reg_en, timeout_err, rd_disp()}, {30'd0, 1'b1, 1'b1, 32'h45464748});
    tick();
    bus.disp_is_done = 1'b1; tick();
    bus.disp_is_done = 1'b0;

    // abort in DWELL with a pending matrix
    offer(1, 32'h61626364); tick();
    offer(0, 32'h0);
    chk("ab_pend", {63'd0, bus.in_ready}, 64'd0);
    abort = 1'b1; tick();
    abort = 1'b0;
    chk("ab_idle", {61'd0, busy, bus.in_ready, frame_done}, {61'd0, 1'b0, 1'b1, 1'b0});
    tick();
    chk("ab_noreload", {30'd0, busy, bus.disp_reg_en, rd_disp()}, {30'd0, 1'b0, 1'b0, 32'h45464748});
    abort = 1'b1; offer(1, 32'h71727374); tick();
    abort = 1'b0; offer(0, 32'h0);
    chk("ab_nocap", {63'd0, bus.in_ready}, 64'd1);
    tick();
    chk("ab_nocap2", {31'd0, busy, rd_disp()}, {31'd0, 1'b0, 32'h45464748});

    // abort during LOAD suppresses the strobe
    offer(1, 32'h81828384); tick();
    offer(0, 32'h0); tick();
    chk("ab_load", {63'd0, bus.disp_reg_en}, 64'd1);
    abort = 1'b1; #1;
    chk("ab_en_forced", {63'd0, bus.disp_reg_en}, 64'd0);
    tick();
    abort = 1'b0;
    chk("ab_load_idle", {31'd0, busy, rd_disp()}, {31'd0, 1'b0, 32'h81828384});

    // asynchronous reset while waiting for done
    offer(1, 32'h91929394); tick();
    offer(0, 32'h0); tick(); tick();
`ifdef DISP_SEQ_FRAME_CNT_EN
    chk("frame_cnt", {48'd0, frame_cnt}, 64'd5);
`endif
    #3 rst = 1'b0;
    #1;
    chk("rst_async", {27'd0, busy, bus.in_ready, timeout_err, bus.disp_reg_en, frame_done, rd_disp()},
        {27'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
`ifdef DISP_SEQ_FRAME_CNT_EN
    chk("frame_cnt_rst", {48'd0, frame_cnt}, 64'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("rst_release", {62'd0, bus.in_ready, busy}, {62'd0, 1'b1, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_sequencer.md
Name: display_sequencer

Overview:
- Sequences the seven-segment display path: accepts 2x2 result matrices (c11..c22, 8-bit each) from the compute side over a valid/ready handshake.
- Buffers one pending matrix and loads each matrix into the display controller with a single-cycle register-enable.
- Waits for the controller's done, holds a dwell period, then reports frame completion.
- Sits between the matrix compute core and the display module; includes a done-timeout watchdog.

Parameters:
- DWELL_CYCLES, 100000000, cycles a frame is held after display done before the next may load (>=1).
- TIMEOUT_CYCLES, 200000000, max cycles to wait for disp_is_done after load (>=2).
- TMR_W, 28, timer width; must hold max(DWELL_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  asynchronous active-low reset
- abort  in  1  synchronous abort; returns to IDLE, drops pending matrix
- in_valid  in  1  matrix offered
- in_ready  out  1  pending slot free
- in_c11, in_c12, in_c21, in_c22  in  8 each  offered matrix elements
- disp_reg_en  out  1  one-cycle load strobe to display controller
- disp_c11, disp_c12, disp_c21, disp_c22  out  8 each  active matrix held stable to display
- disp_is_done  in  1  display controller done indication
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse at end of dwell
- timeout_err  out  1  sticky; set on watchdog expiry, cleared only by reset

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, pend_vld=0, all disp_c*=0, pending regs=0, timer=0, disp_reg_en=0, frame_done=0, timeout_err=0, busy=0. in_ready=1 after reset release.
- in_ready = !pend_vld (combinational from register). Accept on rising edge when in_valid & in_ready: capture in_c* into pending regs, set pend_vld.
- States: IDLE, LOAD, WAIT_DONE, DWELL.
- IDLE: if pend_vld, copy pending to disp_c*, clear pend_vld, go to LOAD. No new acceptance in that cycle, because in_ready=0.
- LOAD: disp_reg_en=1 for exactly this one cycle. Clear timer; go to WAIT_DONE.
- WAIT_DONE:
  - If disp_is_done=1, clear timer and go to DWELL. disp_is_done has priority over timeout in the same cycle.
  - Else if timer==TIMEOUT_CYCLES-1, set timeout_err and go to IDLE with no frame_done.
  - Else increment timer.
- DWELL: increment timer. When timer==DWELL_CYCLES-1, pulse frame_done for one cycle and go to IDLE.
- Latency: matrix accepted at edge N with the FSM idle and slot empty -> disp_reg_en high in the cycle after edge N+1. disp_c* are valid in that same cycle and held unchanged until the next LOAD.
- While a frame is in WAIT_DONE or DWELL, one further matrix may be accepted into the pending slot. A second one stalls (in_ready=0) until IDLE consumes the pending entry.
- Back-to-back: after frame_done, IDLE with pend_vld -> LOAD on the next edge.
- abort=1 (sync, any state): state=IDLE, pend_vld=0, timer=0.
  - No frame_done, disp_reg_en forced 0 that cycle. disp_c* retain last value; timeout_err unchanged.
  - abort overrides a same-cycle accept; the offered matrix is not captured.
- disp_is_done outside WAIT_DONE is ignored.
- Async reset mid-frame returns all outputs to reset values immediately.

Optional Feature:
- Macro DISP_SEQ_FRAME_CNT_EN.
- Defined: adds output frame_cnt [15:0]. Reset 0; increments on every frame_done pulse; wraps 0xFFFF->0x0000. Unaffected by abort and timeout.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Single frame: DWELL_CYCLES=4, TIMEOUT_CYCLES=16.
  - Offer 0x01,0x02,0x03,0x04 one cycle after reset -> disp_reg_en high 2 edges after accept with disp_c*=01/02/03/04.
  - Drive disp_is_done 3 cycles after load -> frame_done pulses exactly 4 cycles after done seen; busy falls the same edge.
- Buffering: offer A, then B during WAIT_DONE, then C.
  - B accepted; C held with in_ready=0 until IDLE consumes B.
  - Display order A, B, C; no matrix lost or duplicated.
- Timeout: never assert disp_is_done.
  - timeout_err rises after 16 cycles in WAIT_DONE; FSM returns to IDLE; no frame_done; next matrix still loads; timeout_err stays 1.
- Done/timeout tie: assert disp_is_done on the cycle timer==15 -> DWELL entered, timeout_err stays 0.
- Abort: assert abort in DWELL with pending B held.
  - Next cycle: IDLE, in_ready=1, no frame_done, no reload of B.
  - Simultaneous abort + in_valid -> matrix not captured.
- Reset mid-WAIT_DONE: drop rst low asynchronously (between edges) -> busy, disp_c*, in_ready and timeout_err at reset values before the next clock edge. With DISP_SEQ_FRAME_CNT_EN, also run 3 frames -> frame_cnt=3.
